// File: rtl/shift_arbiter.sv
// Round-robin arbiter that shares one barrel shifter between the ALU shift path (port 0)
// and the load/store alignment path (port 1); one registered op in flight at a time.
module shift_arbiter #(
  parameter int DPW = 32
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*DPW-1:0]       req_number,
  input  logic [2*$clog2(DPW)-1:0] req_amount,
  input  logic [1:0]             req_is_left,
  input  logic [1:0]             req_msb_ext,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [DPW-1:0]         rsp_data,
  output logic                   busy
);
  localparam int SAW = $clog2(DPW);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic             owner_reg;
  logic [DPW-1:0]   number_reg;
  logic [SAW-1:0]   amount_reg;
  logic             is_left_reg;
  logic             msb_ext_reg;
  logic [DPW-1:0]   data_reg;

  logic             grant;
  logic             handshake;
  logic [DPW-1:0]   number_rev;
  logic [DPW-1:0]   shift_in;
  logic [DPW-1:0]   shift_rev;
  logic [DPW-1:0]   shift_out;
  logic             fill;
  logic [DPW-1:0]   stage [SAW+1];

  // Arbitration: a lone requester wins; under contention the port that lost last time wins.
  always_comb begin
    grant     = 1'b0;
    req_ready = 2'b00;
    if (state_reg == IDLE) begin
      case (req_valid)
        2'b01:   grant = 1'b0;
        2'b10:   grant = 1'b1;
        2'b11:   grant = ~last_grant_reg;
        default: grant = 1'b0;
      endcase
      if (req_valid != 2'b00) begin
        req_ready[grant] = 1'b1;
      end
    end
  end

  assign handshake = (state_reg == IDLE) && (req_valid != 2'b00);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Left shifts reuse the right shifter by reversing the operand on the way in and out.
  generate
    for (genvar gi = 0; gi < DPW; gi++) begin : g_rev
      assign number_rev[gi] = number_reg[DPW-1-gi];
      assign shift_rev[gi]  = stage[SAW][DPW-1-gi];
    end
  endgenerate

  assign shift_in = is_left_reg ? number_rev : number_reg;
  assign fill     = msb_ext_reg & ~is_left_reg & shift_in[DPW-1];
  assign stage[0] = shift_in;

  generate
    for (genvar gi = 0; gi < SAW; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign stage[gi+1] = amount_reg[gi] ? {{SH{fill}}, stage[gi][DPW-1:SH]} : stage[gi];
    end
  endgenerate

  assign shift_out = is_left_reg ? shift_rev : stage[SAW];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      number_reg     <= '0;
      amount_reg     <= '0;
      is_left_reg    <= 1'b0;
      msb_ext_reg    <= 1'b0;
      data_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        owner_reg      <= grant;
        last_grant_reg <= grant;
        number_reg     <= grant ? req_number[2*DPW-1:DPW] : req_number[DPW-1:0];
        amount_reg     <= grant ? req_amount[2*SAW-1:SAW] : req_amount[SAW-1:0];
        is_left_reg    <= req_is_left[grant];
        msb_ext_reg    <= req_msb_ext[grant];
      end
      if (state_reg == EXEC) begin
        data_reg <= shift_out;
      end
    end
  end

  assign rsp_valid = (state_reg == RESP) ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = data_reg;
  assign busy      = (state_reg != IDLE);

endmodule
